// File: rtl/hsv_pkg.sv
// Shared constants and types for the HSV colour-tracking pipeline.
package hsv_pkg;

  localparam int HUE_MAX   = 360;
  localparam int HUE_W     = 9;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } bbox_state_t;

endpackage

// File: rtl/hue_range_cmp.sv
// Combinational hue window test; a window with lo > hi wraps through 0 degrees.
module hue_range_cmp
  import hsv_pkg::*;
(
  input  logic [15:0]      i_hue,
  input  logic [HUE_W-1:0] i_lo,
  input  logic [HUE_W-1:0] i_hi,
  output logic             o_in_range
);

  logic hue_ok;
  logic ge_lo;
  logic le_hi;

  always_comb begin
    hue_ok = i_hue < 16'(HUE_MAX);
    ge_lo  = i_hue >= 16'(i_lo);
    le_hi  = i_hue <= 16'(i_hi);
    if (i_lo <= i_hi) o_in_range = hue_ok & ge_lo & le_hi;
    else              o_in_range = hue_ok & (ge_lo | le_hi);
  end

endmodule

// File: rtl/hue_bbox.sv
// Per-frame bounding box and pixel count of pixels whose hue lies inside a window.
module hue_bbox
  import hsv_pkg::*;
#(
  parameter  int IMG_W = IMG_W_DEF,
  parameter  int IMG_H = IMG_H_DEF,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sof,
  input  logic [15:0]   i_data,
  input  logic          i_valid,
  input  logic [8:0]    i_hue_lo,
  input  logic [8:0]    i_hue_hi,
  output logic          o_mask,
  output logic          o_mask_valid,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [YW-1:0] o_ymin,
  output logic [YW-1:0] o_ymax,
  output logic [CW-1:0] o_count,
  output logic          o_found,
  output logic          o_valid
);

  bbox_state_t state_q, state_d;

  logic [HUE_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [XW-1:0]    x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]    y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [XW-1:0]    oxmin_q, oxmin_d, oxmax_q, oxmax_d;
  logic [YW-1:0]    oymin_q, oymin_d, oymax_q, oymax_d;
  logic [CW-1:0]    ocount_q, ocount_d;
  logic             found_q, found_d, valid_q, valid_d;
  logic             mask_q, mask_d, mask_valid_q, mask_valid_d;

  logic in_range;
  logic accum_en;
  logic publish;
  logic x_last;
  logic last_pix;

  hue_range_cmp u_cmp (
    .i_hue      (i_data),
    .i_lo       (lo_q),
    .i_hi       (hi_q),
    .o_in_range (in_range)
  );

  assign x_last   = x_q == XW'(IMG_W - 1);
  assign last_pix = accum_en && i_valid && x_last && (y_q == YW'(IMG_H - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_sof) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!i_sof && last_pix) state_d = ST_DONE;
      ST_DONE:   state_d = i_sof ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A start-of-frame always wins over pixel accumulation, which is how a mid-frame abort restarts.
  always_comb begin
    accum_en = (state_q == ST_ACTIVE) && !i_sof;
    publish  = (state_q == ST_DONE);
  end

  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    x_d    = x_q;
    y_d    = y_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (i_sof) begin
      lo_d   = i_hue_lo;
      hi_d   = i_hue_hi;
      x_d    = '0;
      y_d    = '0;
      xmin_d = '1;
      xmax_d = '0;
      ymin_d = '1;
      ymax_d = '0;
      cnt_d  = '0;
    end else if (accum_en && i_valid) begin
      if (in_range) begin
        if (x_q < xmin_q) xmin_d = x_q;
        if (x_q > xmax_q) xmax_d = x_q;
        if (y_q < ymin_q) ymin_d = y_q;
        if (y_q > ymax_q) ymax_d = y_q;
        cnt_d = cnt_q + CW'(1);
      end
      if (x_last) begin
        x_d = '0;
        y_d = last_pix ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    oxmin_d      = oxmin_q;
    oxmax_d      = oxmax_q;
    oymin_d      = oymin_q;
    oymax_d      = oymax_q;
    ocount_d     = ocount_q;
    found_d      = found_q;
    valid_d      = 1'b0;
    mask_d       = i_valid & in_range;
    mask_valid_d = i_valid;
    if (publish) begin
      found_d  = cnt_q != '0;
      valid_d  = 1'b1;
      ocount_d = cnt_q;
      oxmin_d  = found_d ? xmin_q : '0;
      oxmax_d  = found_d ? xmax_q : '0;
      oymin_d  = found_d ? ymin_q : '0;
      oymax_d  = found_d ? ymax_q : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lo_q         <= '0;
      hi_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xmin_q       <= '1;
      xmax_q       <= '0;
      ymin_q       <= '1;
      ymax_q       <= '0;
      cnt_q        <= '0;
      oxmin_q      <= '0;
      oxmax_q      <= '0;
      oymin_q      <= '0;
      oymax_q      <= '0;
      ocount_q     <= '0;
      found_q      <= 1'b0;
      valid_q      <= 1'b0;
      mask_q       <= 1'b0;
      mask_valid_q <= 1'b0;
    end else begin
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cnt_q        <= cnt_d;
      oxmin_q      <= oxmin_d;
      oxmax_q      <= oxmax_d;
      oymin_q      <= oymin_d;
      oymax_q      <= oymax_d;
      ocount_q     <= ocount_d;
      found_q      <= found_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      mask_valid_q <= mask_valid_d;
    end
  end

  assign o_mask       = mask_q;
  assign o_mask_valid = mask_valid_q;
  assign o_xmin       = oxmin_q;
  assign o_xmax       = oxmax_q;
  assign o_ymin       = oymin_q;
  assign o_ymax       = oymax_q;
  assign o_count      = ocount_q;
  assign o_found      = found_q;
  assign o_valid      = valid_q;

endmodule

// File: tb/tb_hue_bbox.sv
// Directed bench for hue_bbox on an 8x4 frame with hand-computed box results.
module tb_hue_bbox;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_sof = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic [8:0]  i_hue_lo = '0;
  logic [8:0]  i_hue_hi = '0;
  logic        o_mask, o_mask_valid, o_found, o_valid;
  logic [2:0]  o_xmin, o_xmax;
  logic [1:0]  o_ymin, o_ymax;
  logic [5:0]  o_count;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  int cur_lo   = 0;
  int cur_hi   = 0;
  int v0;
  logic [15:0] pix [NP];

  hue_bbox #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sof(i_sof), .i_data(i_data),
    .i_valid(i_valid), .i_hue_lo(i_hue_lo), .i_hue_hi(i_hue_hi),
    .o_mask(o_mask), .o_mask_valid(o_mask_valid),
    .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax),
    .o_count(o_count), .o_found(o_found), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_valid) vcount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic ref_in_range(input int h);
    if (h > 359) return 1'b0;
    if (cur_lo <= cur_hi) return (h >= cur_lo) && (h <= cur_hi);
    return (h >= cur_lo) || (h <= cur_hi);
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill(input int bg);
    for (int i = 0; i < NP; i++) pix[i] = 16'(bg);
  endtask

  task automatic send_sof(input int lo, input int hi);
    i_sof = 1'b1; i_hue_lo = 9'(lo); i_hue_hi = 9'(hi);
    cur_lo = lo; cur_hi = hi;
    step();
    i_sof = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int gap_max, input bit chk_mask);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        i_valid = 1'b0;
        step();
        if (chk_mask) check("mask_valid_gap", 32'(o_mask_valid), 0);
      end
      i_valid = 1'b1; i_data = pix[i];
      step();
      if (chk_mask) begin
        check("mask_valid", 32'(o_mask_valid), 1);
        check("mask", 32'(o_mask), 32'(ref_in_range(int'(pix[i]))));
      end
      i_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input int xmn, input int xmx,
                              input int ymn, input int ymx, input int cnt, input int fnd);
    check({tag, "_xmin"},  32'(o_xmin),  xmn);
    check({tag, "_xmax"},  32'(o_xmax),  xmx);
    check({tag, "_ymin"},  32'(o_ymin),  ymn);
    check({tag, "_ymax"},  32'(o_ymax),  ymx);
    check({tag, "_count"}, 32'(o_count), cnt);
    check({tag, "_found"}, 32'(o_found), fnd);
  endtask

  // Called right after the final pixel's edge: o_valid must appear exactly one edge later.
  task automatic finish_frame(input string tag, input int xmn, input int xmx,
                              input int ymn, input int ymx, input int cnt, input int fnd);
    v0 = vcount;
    check({tag, "_valid_early"}, 32'(o_valid), 0);
    step();
    check({tag, "_valid"}, 32'(o_valid), 1);
    check_result(tag, xmn, xmx, ymn, ymx, cnt, fnd);
    step();
    check({tag, "_valid_pulse"}, 32'(o_valid), 0);
    check_result({tag, "_hold"}, xmn, xmx, ymn, ymx, cnt, fnd);
    check({tag, "_npulse"}, 32'(vcount - v0), 1);
  endtask

  initial begin
    i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    check_result("reset", 0, 0, 0, 0, 0, 0);
    check("reset_valid", 32'(o_valid), 0);
    check("reset_mask_valid", 32'(o_mask_valid), 0);
    step();

    // hue 120 at (2,1) and (5,3)
    fill(0); pix[10] = 16'd120; pix[29] = 16'd120;
    send_sof(100, 140);
    send_pixels(NP, 0, 1'b1);
    finish_frame("basic", 2, 5, 1, 3, 2, 1);

    // nothing in range: results forced to 0
    fill(0);
    send_sof(100, 140);
    send_pixels(NP, 0, 1'b1);
    finish_frame("none", 0, 0, 0, 0, 0, 0);

    // inclusive bounds: 100 at (7,0), 140 at (0,2); 99 and 141 excluded
    fill(0); pix[7] = 16'd100; pix[16] = 16'd140; pix[0] = 16'd99; pix[31] = 16'd141;
    send_sof(100, 140);
    send_pixels(NP, 0, 1'b1);
    finish_frame("bounds", 0, 7, 0, 2, 2, 1);

    // abort after 10 pixels, then a full wrap-window frame
    v0 = vcount;
    fill(120);
    send_sof(100, 140);
    send_pixels(10, 0, 1'b1);
    check_result("abort_hold", 0, 7, 0, 2, 2, 1);
    fill(180); pix[0] = 16'd350; pix[31] = 16'd10; pix[15] = 16'd360;
    send_sof(340, 20);
    send_pixels(NP, 0, 1'b1);
    check("abort_no_pulse", 32'(vcount - v0), 0);
    finish_frame("wrap", 0, 7, 0, 3, 2, 1);

    // random gaps plus out-of-range hue 400: same result as the basic frame
    fill(0); pix[10] = 16'd120; pix[29] = 16'd120; pix[3] = 16'd400; pix[20] = 16'd400;
    send_sof(100, 140);
    send_pixels(NP, 3, 1'b1);
    finish_frame("gaps", 2, 5, 1, 3, 2, 1);

    // reset mid-frame coincident with a valid pixel
    fill(120);
    send_sof(100, 140);
    send_pixels(10, 0, 1'b1);
    i_rst = 1'b1; i_valid = 1'b1; i_data = 16'd120;
    step();
    i_rst = 1'b0; i_valid = 1'b0;
    check_result("rst", 0, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_mask_valid", 32'(o_mask_valid), 0);
    check("rst_mask", 32'(o_mask), 0);
    v0 = vcount;
    send_pixels(NP, 0, 1'b0);
    step(); step(); step();
    check("rst_no_sof_pulse", 32'(vcount - v0), 0);
    check_result("rst_idle", 0, 0, 0, 0, 0, 0);
    fill(0); pix[10] = 16'd120; pix[29] = 16'd120;
    send_sof(100, 140);
    send_pixels(NP, 0, 1'b1);
    finish_frame("after_rst", 2, 5, 1, 3, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
